// File: rtl/fifo_skew_pkg.sv
// Shared types and width helpers for the skewed row-FIFO read scheduler.
package fifo_skew_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // The step counter must reach len + NROWS - 2 without wrapping, plus a spare bit.
  function automatic int cnt_w(input int len_w, input int nrows);
    return len_w + $clog2(nrows) + 1;
  endfunction

endpackage

// File: rtl/skew_window.sv
// Wavefront step counter with per-row active-window decode.
// Row i is active while i <= t < i + len_q.
module skew_window
  import fifo_skew_pkg::*;
#(
  parameter int NROWS = 4,
  parameter int LEN_W = 8,
  parameter int CNT_W = cnt_w(LEN_W, NROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic [LEN_W-1:0] len_q,
  output logic [CNT_W-1:0] t,
  output logic [NROWS-1:0] need,
  output logic             last
);

  logic [CNT_W-1:0] t_q, t_d;
  logic [CNT_W-1:0] len_ext;

  assign len_ext = {{(CNT_W-LEN_W){1'b0}}, len_q};

  always_comb begin
    t_d = t_q;
    if (clr) begin
      t_d = '0;
    end else if (adv) begin
      t_d = t_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q <= '0;
    end else begin
      t_q <= t_d;
    end
  end

  for (genvar i = 0; i < NROWS; i++) begin : g_row
    localparam logic [CNT_W-1:0] LO = CNT_W'(i);
    assign need[i] = (t_q >= LO) && (t_q < (LO + len_ext));
  end

  // Final step is the one where the last row pops its last entry.
  assign last = (t_q == (len_ext + CNT_W'(NROWS - 2)));
  assign t    = t_q;

endmodule

// File: rtl/fifo_skew_sched.sv
// Read-side sequencer for NROWS row FIFOs: issues a diagonal wavefront of ren
// pulses, freezing the whole wavefront when a due row is empty or en is low.
module fifo_skew_sched
  import fifo_skew_pkg::*;
#(
  parameter int NROWS = 4,
  parameter int LEN_W = 8,
  parameter int CNT_W = cnt_w(LEN_W, NROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             en,
  input  logic [NROWS-1:0] empty,
  output logic [NROWS-1:0] ren,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  sched_state_t     state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             clr, adv, last;
  logic [NROWS-1:0] need;
  logic [CNT_W-1:0] t_unused;

  skew_window #(
    .NROWS (NROWS),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) u_window (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .adv   (adv),
    .len_q (len_q),
    .t     (t_unused),
    .need  (need),
    .last  (last)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    clr     = 1'b0;
    adv     = 1'b0;
    ren     = '0;
    busy    = 1'b0;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        clr = 1'b1;
        if (start) begin
          if (len != '0) begin
            len_d   = len;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        busy  = 1'b1;
        // All-or-nothing: a wavefront step never pops a subset of its rows.
        stall = ~en | (|(need & empty));
        adv   = ~stall;
        ren   = need & {NROWS{~stall}};
        if (!stall && last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_fifo_skew_sched.sv
// Directed, table-driven bench for fifo_skew_sched (NROWS=4, LEN_W=8).
module tb_fifo_skew_sched;

  localparam int NROWS = 4;
  localparam int LEN_W = 8;

  typedef struct packed {
    logic             start;
    logic [LEN_W-1:0] len;
    logic             en;
    logic [NROWS-1:0] empty;
    logic [NROWS-1:0] ren;
    logic             busy;
    logic             stall;
    logic             done;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             en = 1'b1;
  logic [NROWS-1:0] empty = '0;
  logic [NROWS-1:0] ren;
  logic             busy, stall, done;

  vec_t             vecs[$];
  logic [NROWS-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_fail = 0;
  int               row_cnt[NROWS];
  int               done_cnt = 0;

  fifo_skew_sched #(.NROWS(NROWS), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .len   (len),
    .en    (en),
    .empty (empty),
    .ren   (ren),
    .busy  (busy),
    .stall (stall),
    .done  (done)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: act=%h req=%h", name, $time, act, req);
    end
  endtask

  task automatic add(input logic s, input int l, input logic e, input logic [3:0] emp,
                     input logic [3:0] r, input logic b, input logic st, input logic d);
    vec_t v;
    v.start = s; v.len = LEN_W'(l); v.en = e; v.empty = emp;
    v.ren = r; v.busy = b; v.stall = st; v.done = d;
    vecs.push_back(v);
  endtask

  // Driver: apply one vector away from the rising edge, then check.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    start = v.start; len = v.len; en = v.en; empty = v.empty;
    #1;
    chk($sformatf("ren[%0d]", idx),   32'(ren),   32'(v.ren));
    chk($sformatf("busy[%0d]", idx),  32'(busy),  32'(v.busy));
    chk($sformatf("stall[%0d]", idx), 32'(stall), 32'(v.stall));
    chk($sformatf("done[%0d]", idx),  32'(done),  32'(v.done));
    for (int i = 0; i < NROWS; i++) row_cnt[i] += int'(ren[i]);
    done_cnt += int'(done);
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
    vecs.delete();
  endtask

  task automatic add_basic();
    add(1, 3, 1, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b0001, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b0011, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b0111, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b1110, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b1100, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b1000, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b0000, 1, 0, 1);
    add(0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < NROWS; i++) row_cnt[i] = 0;

    // Reset state
    #2;
    chk("rst_ren", 32'(ren), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: basic len=3 wavefront
    add_basic();
    // 2: row 2 empty for two cycles on the third RUN step
    add(1, 3, 1, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b0001, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b0011, 1, 0, 0);
    add(0, 0, 1, 4'b0100, 4'b0000, 1, 1, 0);
    add(0, 0, 1, 4'b0100, 4'b0000, 1, 1, 0);
    add(0, 0, 1, 4'b0000, 4'b0111, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b1110, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b1100, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b1000, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b0000, 1, 0, 1);
    add(0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0);
    // 3: len=0 goes straight to DONE
    add(1, 0, 1, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b0000, 1, 0, 1);
    add(0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0);
    // 4: start with len=5 during RUN is ignored
    add(1, 3, 1, 4'b0000, 4'b0000, 0, 0, 0);
    add(1, 5, 1, 4'b0000, 4'b0001, 1, 0, 0);
    add(1, 5, 1, 4'b0000, 4'b0011, 1, 0, 0);
    add(1, 5, 1, 4'b0000, 4'b0111, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b1110, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b1100, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b1000, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b0000, 1, 0, 1);
    add(0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0);
    // 6: en low for three cycles; an empty row that is not due does not stall
    add(1, 3, 1, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 0, 1, 4'b1000, 4'b0001, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b0011, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b0111, 1, 0, 0);
    add(0, 0, 0, 4'b0000, 4'b0000, 1, 1, 0);
    add(0, 0, 0, 4'b0000, 4'b0000, 1, 1, 0);
    add(0, 0, 0, 4'b0000, 4'b0000, 1, 1, 0);
    add(0, 0, 1, 4'b0000, 4'b1110, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b1100, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b1000, 1, 0, 0);
    add(0, 0, 1, 4'b0000, 4'b0000, 1, 0, 1);
    add(0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0);
    run_table();

    // Four len=3 transfers and one len=0 transfer so far.
    for (int i = 0; i < NROWS; i++) chk($sformatf("row_cnt[%0d]", i), 32'(row_cnt[i]), 32'd12);
    chk("done_cnt", 32'(done_cnt), 32'd5);

    // 5: asynchronous reset in the middle of the second RUN cycle
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0011);
    @(negedge clk);
    start = 1'b1; len = 8'd3; en = 1'b1; empty = '0;
    @(negedge clk);
    start = 1'b0; len = '0;
    #1 chk("rst5_run1", 32'(ren), 32'(exp_q.pop_front()));
    @(negedge clk);
    #1 chk("rst5_run2", 32'(ren), 32'(exp_q.pop_front()));
    #1 rst = 1'b1;
    #1;
    chk("rst5_ren", 32'(ren), 32'h0);
    chk("rst5_busy", 32'(busy), 32'h0);
    chk("rst5_done", 32'(done), 32'h0);
    chk("rst5_stall", 32'(stall), 32'h0);
    @(negedge clk);
    chk("rst5_hold_ren", 32'(ren), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < NROWS; i++) row_cnt[i] = 0;
    done_cnt = 0;
    add_basic();
    run_table();
    for (int i = 0; i < NROWS; i++) chk($sformatf("post_rst_cnt[%0d]", i), 32'(row_cnt[i]), 32'd3);
    chk("post_rst_done", 32'(done_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_skew_sched.md
Name: fifo_skew_sched

Overview:
- Sequences the read side of NROWS row-feeder FIFOs into the systolic array.
- Generates the diagonal (skewed) wavefront: row i pops i cycles after row 0, each row pops exactly LEN entries.
- Stalls the whole wavefront when any row due to pop is empty or the array is not stepping.
- Sits between the NPU top-level control (start/len) and the FIFO ren inputs. FIFO q is combinational on ren, so data is valid in the cycle ren is high.

Parameters:
NROWS, 4, number of row FIFOs / array rows
LEN_W, 8, width of the per-row transfer length
CNT_W, LEN_W+$clog2(NROWS)+1, width of internal step counter t

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  begin a transfer; sampled only in IDLE
len  input  LEN_W  entries per row; sampled with start
en  input  1  array step enable; low freezes the schedule
empty  input  NROWS  empty flag of each row FIFO
ren  output  NROWS  read enable to each row FIFO
busy  output  1  high in RUN and DONE
stall  output  1  RUN and schedule frozen this cycle
done  output  1  one-cycle pulse at end of transfer

Behaviour:
- Reset: async, active-high. Forces state=IDLE, t=0, len_q=0. Outputs ren=0, busy=0, stall=0, done=0 immediately, independent of clk. Reset mid-RUN aborts with no further ren. FIFO contents are the FIFOs' own concern.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with len!=0: latch len_q=len, t=0, next state RUN.
  - start=1 with len==0: next state DONE; no ren ever asserted.
  - start=0: stay in IDLE.
- RUN:
  - Row i is active when i <= t < i+len_q. Compare at CNT_W bits (zero-extend len_q; no overflow).
  - need = active vector.
  - stall = ~en | (|(need & empty)).
  - ren = need & {NROWS{~stall}}.
  - No stall: t increments.
  - No stall and t == len_q+NROWS-2: next state DONE.
  - Stall: t holds and ren is all-zero. A transfer never partially pops a wavefront step.
- DONE: done=1, busy=1, ren=0 for exactly one cycle, then IDLE.
- start outside IDLE is ignored; len is not re-sampled.
- Latency: start at edge k gives first RUN cycle k+1. With no stalls, RUN lasts len_q+NROWS-1 cycles, then 1 DONE cycle.
- Each row i sees exactly len_q ren pulses per transfer. Row i's first pulse comes i unstalled steps after row 0's.
- The schedule relies on the empty flags only. A FIFO is never read while empty because ren is masked.
- Maximum len = 2^LEN_W-1. The counter never wraps.

Decomposition:
- Package fifo_skew_pkg holds:
  - typedef enum logic [1:0] sched_state_t {IDLE, RUN, DONE}
  - the CNT_W derivation function.
- Sub-module skew_window: combinational-free registered step counter plus per-row window compare.
  - Inputs: clk, rst, clr, adv, len_q.
  - Outputs: t, need[NROWS], last.
  - The top holds the FSM and the stall/ren masking.

Test Plan:
1. NROWS=4, len=3, en=1, empty=0, start pulsed 1 cycle:
   - ren per RUN cycle is 0001, 0011, 0111, 1110, 1100, 1000.
   - busy=1 for 7 cycles; done=1 on the 7th cycle; total ren pulses per row = 3.
2. Same as 1, but empty[2]=1 during the third RUN cycle for 2 cycles:
   - stall=1 and ren=0000 for those 2 cycles; t holds.
   - The sequence then resumes at 0111; done is delayed by exactly 2 cycles.
3. len=0 with start → next cycle done=1, busy=1, ren=0000 throughout; IDLE the cycle after.
4. start=1 with len=5 asserted again during RUN of a len=3 transfer → ignored; still 3 pulses per row and a single done.
5. rst asserted asynchronously mid-cycle during the second RUN cycle:
   - ren=0000, busy=0, done=0 immediately, before the next edge.
   - After release, IDLE accepts a new start normally.
6. en=0 for 3 cycles mid-transfer (empty=0) → stall=1, ren=0000 for 3 cycles; per-row counts still equal len; done delayed by 3 cycles.
